// File: rtl/trb_mem_ctrl_pkg.sv
// Shared Tracer constants, the memory-controller state type and its default depth.
package trb_mem_ctrl_pkg;

  localparam int TRB_WIDTH       = 32;
  localparam int TRB_MAX_TRACES  = 8;
  localparam int TRB_NTRACE_BITS = $clog2(TRB_MAX_TRACES);
  localparam int TRB_POS_W       = $clog2(TRB_WIDTH);
  localparam int TRB_MEM_DEPTH   = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_POST,
    ST_DONE,
    ST_S_WAIT,
    ST_S_READ,
    ST_S_LOAD
  } mem_ctrl_state_t;

endpackage

// File: rtl/trb_mem_ctrl_if.sv
// Bundle between the trace memory controller (slave) and its surroundings (master):
// the run controls, the Tracer word/stream handshake, the memory port and the trigger status.
// With TRB_WRAP_FLAG_EN defined, an extra wrapped flag reports that the ring buffer wrapped.
interface trb_mem_ctrl_if #(
  parameter int ADDR_W = $clog2(trb_mem_ctrl_pkg::TRB_MEM_DEPTH)
) ();

  localparam int W     = trb_mem_ctrl_pkg::TRB_WIDTH;
  localparam int POS_W = trb_mem_ctrl_pkg::TRB_POS_W;

  // run control
  logic              en;
  logic              mode;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W:0]   fill_ptr;
  // Tracer side
  logic              store;
  logic [W-1:0]      data;
  logic              trg_event;
  logic [POS_W-1:0]  event_pos;
  logic              req;
  logic              load;
  logic [W-1:0]      data_out;
  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [W-1:0]      mem_wdata;
  logic [W-1:0]      mem_rdata;
  // status
  logic [ADDR_W-1:0] trg_addr;
  logic [POS_W-1:0]  trg_pos;
  logic              triggered;
  logic              done;
`ifdef TRB_WRAP_FLAG_EN
  logic              wrapped;
`endif

  modport slave (
    input  en, mode, post_cnt, fill_ptr,
    input  store, data, trg_event, event_pos, req,
    output load, data_out,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output trg_addr, trg_pos, triggered, done
`ifdef TRB_WRAP_FLAG_EN
    , output wrapped
`endif
  );

  modport master (
    output en, mode, post_cnt, fill_ptr,
    output store, data, trg_event, event_pos, req,
    input  load, data_out,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  trg_addr, trg_pos, triggered, done
`ifdef TRB_WRAP_FLAG_EN
    , input wrapped
`endif
  );

endinterface

// File: rtl/trb_mem_ctrl.sv
// Sequencer between the Tracer serializer and a single-port trace memory (1-cycle read latency).
// Trace mode ring-buffers stored words, latches the trigger word address and bit position and
// stops after a programmable number of post-trigger words. Stream mode answers Tracer requests
// with a LOAD pulse plus the next word read sequentially from address 0, gated by the host
// fill pointer.
// Optional feature: define TRB_WRAP_FLAG_EN to add the wrapped flag (ring buffer wrapped).
module trb_mem_ctrl
  import trb_mem_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = TRB_MEM_DEPTH
) (
  input logic           clk,
  input logic           rst,
  trb_mem_ctrl_if.slave bus
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   RPTR_ONE  = (ADDR_W + 1)'(1);

  mem_ctrl_state_t   state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W:0]   rptr;      // extra MSB tells full from empty against fill_ptr
  logic [ADDR_W:0]   fill_lvl;
  logic              non_empty;
  logic              store_ok;
  logic              trace_state;

  assign trace_state = (state == ST_PRE) || (state == ST_POST);
  assign store_ok    = !rst && bus.en && bus.store && trace_state;
  assign fill_lvl    = bus.fill_ptr - rptr;
  assign non_empty   = (fill_lvl != '0);

  // Memory port: writes follow STORE combinationally, reads address the stream pointer.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred on unlisted paths.
    bus.mem_we    = store_ok;
    bus.mem_wdata = '0;
    bus.mem_addr  = '0;
    if (store_ok) bus.mem_wdata = bus.data;
    unique case (state)
      ST_PRE, ST_POST:                bus.mem_addr = wptr;
      ST_S_WAIT, ST_S_READ, ST_S_LOAD: bus.mem_addr = rptr[ADDR_W-1:0];
      default:                        bus.mem_addr = '0;
    endcase
  end

  // Main sequencer: state, pointers and registered status/stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wptr          <= '0;
      rptr          <= '0;
      post_cnt      <= '0;
      bus.load      <= 1'b0;
      bus.data_out  <= '0;
      bus.trg_addr  <= '0;
      bus.trg_pos   <= '0;
      bus.triggered <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      bus.load <= 1'b0;
      if (!bus.en) begin
        state         <= ST_IDLE;
        bus.triggered <= 1'b0;
        bus.done      <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            wptr     <= '0;
            rptr     <= '0;
            post_cnt <= '0;
            state    <= bus.mode ? ST_S_WAIT : ST_PRE;
          end
          ST_PRE: begin
            if (bus.store) begin
              wptr <= wptr + ADDR_ONE;
              if (bus.trg_event) begin
                bus.trg_addr  <= wptr;
                bus.trg_pos   <= bus.event_pos;
                bus.triggered <= 1'b1;
                if (bus.post_cnt == '0) begin
                  state    <= ST_DONE;
                  bus.done <= 1'b1;
                end else begin
                  state <= ST_POST;
                end
              end
            end
          end
          ST_POST: begin
            if (bus.store) begin
              wptr     <= wptr + ADDR_ONE;
              post_cnt <= post_cnt + ADDR_ONE;
              if ((post_cnt + ADDR_ONE) == bus.post_cnt) begin
                state    <= ST_DONE;
                bus.done <= 1'b1;
              end
            end
          end
          ST_DONE: state <= ST_DONE;
          ST_S_WAIT: begin
            if (bus.req && non_empty) state <= ST_S_READ;
          end
          ST_S_READ: begin
            // read data for rptr is on mem_rdata during this cycle
            bus.load     <= 1'b1;
            bus.data_out <= bus.mem_rdata;
            state        <= ST_S_LOAD;
          end
          ST_S_LOAD: begin
            rptr  <= rptr + RPTR_ONE;
            state <= ST_S_WAIT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TRB_WRAP_FLAG_EN
  // Wrap flag: a write at the last address means the buffer start is now wptr, not 0.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      bus.wrapped <= 1'b0;
    end else if (store_ok && (wptr == ADDR_LAST)) begin
      bus.wrapped <= 1'b1;
    end
  end
`endif

endmodule
